// File: rtl/oled_spi_tx.sv
// oled_spi_tx: buffered MSB-first SPI transmitter for the SSD1331 (PmodOLEDrgb) controller.
// Define OLED_SPI_TX_WORD_COUNT_EN to add the word_count output (completed entries, wraps).
module oled_spi_tx #(
  parameter int CLK_DIV = 4,
  parameter int DEPTH   = 8,
  parameter int WORD_W  = 16,
  parameter int CS_IDLE = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD_W-1:0]      in_data,
  input  logic                   in_dc,
  input  logic                   in_wide,
  output logic                   cs,
  output logic                   sclk,
  output logic                   sdin,
  output logic                   dc,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level
`ifdef OLED_SPI_TX_WORD_COUNT_EN
  ,
  output logic [15:0]            word_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = WORD_W + 2;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;
  localparam logic [LW-1:0] FULL     = LW'(DEPTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_IDLE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [EW-1:0]     mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level_next;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic [EW-1:0]     head;
  logic              head_dc;
  logic              head_wide;
  logic [WORD_W-1:0] head_data;
  logic [WORD_W-1:0] load_word;

  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] shreg_next;
  logic [DW-1:0]     div_cnt;
  logic [DW-1:0]     div_next;
  logic              phase;
  logic              phase_next;
  logic [3:0]        bits_left;
  logic [3:0]        bits_next;
  logic [GW-1:0]     gap_cnt;
  logic [GW-1:0]     gap_next;
  logic              cur_dc;
  logic              cur_dc_next;

  // Narrow entries are left-justified so the shifter always emits from the MSB.
  function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] d, input logic w);
    if (WORD_W == 16 && w) begin
      return d;
    end else begin
      return WORD_W'(d[7:0]) << (WORD_W - 8);
    end
  endfunction

  function automatic logic [3:0] last_bit_idx(input logic w);
    if (WORD_W == 16 && w) begin
      return 4'd15;
    end else begin
      return 4'd7;
    end
  endfunction

  assign push       = in_valid && in_ready;
  assign fifo_empty = (fifo_level == {LW{1'b0}});
  assign head       = mem[rd_ptr];
  assign head_dc    = head[EW-1];
  assign head_wide  = head[EW-2];
  assign head_data  = head[WORD_W-1:0];
  assign load_word  = align_word(head_data, head_wide);

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_dc, in_wide, in_data};
    end
  end

  // FIFO occupancy bookkeeping
  always_comb begin
    level_next = fifo_level;
    case ({push, pop})
      2'b10:   level_next = fifo_level + LW'(1);
      2'b01:   level_next = fifo_level - LW'(1);
      default: level_next = fifo_level;
    endcase
  end

  // FIFO pointers, occupancy and ready flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= {AW{1'b0}};
      rd_ptr     <= {AW{1'b0}};
      fifo_level <= {LW{1'b0}};
      in_ready   <= 1'b1;
    end else begin
      fifo_level <= level_next;
      in_ready   <= (level_next != FULL);
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and shifter control; a pop always (re)starts SHIFT with a fresh entry
  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    shreg_next  = shreg;
    div_next    = div_cnt;
    phase_next  = phase;
    bits_next   = bits_left;
    gap_next    = gap_cnt;
    cur_dc_next = cur_dc;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        if (div_cnt != DIV_LAST) begin
          div_next = div_cnt + DW'(1);
        end else if (!phase) begin
          div_next   = {DW{1'b0}};
          phase_next = 1'b1;
        end else if (bits_left != 4'd0) begin
          div_next   = {DW{1'b0}};
          phase_next = 1'b0;
          shreg_next = shreg << 1;
          bits_next  = bits_left - 4'd1;
        end else if (!fifo_empty && head_dc == cur_dc) begin
          pop = 1'b1;
        end else begin
          state_next = GAP;
          gap_next   = {GW{1'b0}};
        end
      end
      GAP: begin
        if (gap_cnt != GAP_LAST) begin
          gap_next = gap_cnt + GW'(1);
        end else if (!fifo_empty) begin
          pop = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (pop) begin
      state_next  = SHIFT;
      shreg_next  = load_word;
      div_next    = {DW{1'b0}};
      phase_next  = 1'b0;
      bits_next   = last_bit_idx(head_wide);
      cur_dc_next = head_dc;
    end else begin
      cur_dc_next = cur_dc;
    end
  end

  // Shifter datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg     <= {WORD_W{1'b0}};
      div_cnt   <= {DW{1'b0}};
      phase     <= 1'b0;
      bits_left <= 4'd0;
      gap_cnt   <= {GW{1'b0}};
      cur_dc    <= 1'b0;
    end else begin
      shreg     <= shreg_next;
      div_cnt   <= div_next;
      phase     <= phase_next;
      bits_left <= bits_next;
      gap_cnt   <= gap_next;
      cur_dc    <= cur_dc_next;
    end
  end

  // Pin registers: decoded from the shifter one cycle behind, so every pin is a flop
  always_ff @(posedge clk) begin
    if (rst) begin
      cs   <= 1'b1;
      sclk <= 1'b0;
      sdin <= 1'b0;
      dc   <= 1'b0;
      busy <= 1'b0;
    end else begin
      cs   <= (state != SHIFT);
      sclk <= (state == SHIFT) && phase;
      sdin <= (state == SHIFT) && shreg[WORD_W-1];
      dc   <= cur_dc;
      busy <= (level_next != {LW{1'b0}}) || (state_next != IDLE);
    end
  end

`ifdef OLED_SPI_TX_WORD_COUNT_EN
  logic entry_done;

  assign entry_done = (state == SHIFT) && phase && (div_cnt == DIV_LAST) && (bits_left == 4'd0);

  // Completed-entry counter; reset-aborted entries never reach entry_done
  always_ff @(posedge clk) begin
    if (rst) begin
      word_count <= 16'd0;
    end else if (entry_done) begin
      word_count <= word_count + 16'd1;
    end else begin
      word_count <= word_count;
    end
  end
`endif

endmodule

// File: tb/tb_oled_spi_tx.sv
// tb_oled_spi_tx: directed self-checking bench for oled_spi_tx with default parameters.
// Monitors record sdin/dc at each sclk rise and the lengths of cs-low windows and cs-high gaps.
module tb_oled_spi_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_dc;
  logic        in_wide;
  logic        cs;
  logic        sclk;
  logic        sdin;
  logic        dc;
  logic        busy;
  logic [3:0]  fifo_level;
`ifdef OLED_SPI_TX_WORD_COUNT_EN
  logic [15:0] word_count;
`endif

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  logic bits[$];
  logic bdc[$];
  int   lows[$];
  int   gaps[$];
  int   lo_run   = 0;
  int   hi_run   = 0;
  int   dc_viol  = 0;
  bit   seen_lo  = 1'b0;
  logic prev_dc  = 1'b0;
  logic prev_cs  = 1'b1;

  oled_spi_tx #(.CLK_DIV(4), .DEPTH(8), .WORD_W(16), .CS_IDLE(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_dc      (in_dc),
    .in_wide    (in_wide),
    .cs         (cs),
    .sclk       (sclk),
    .sdin       (sdin),
    .dc         (dc),
    .busy       (busy),
    .fifo_level (fifo_level)
`ifdef OLED_SPI_TX_WORD_COUNT_EN
    ,
    .word_count (word_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge sclk) begin
    bits.push_back(sdin);
    bdc.push_back(dc);
  end

  always @(negedge clk) begin
    if (cs === 1'b0) begin
      if (lo_run == 0 && seen_lo) gaps.push_back(hi_run);
      lo_run++;
    end else begin
      if (lo_run != 0) begin
        lows.push_back(lo_run);
        seen_lo = 1'b1;
        hi_run  = 0;
      end
      lo_run = 0;
      hi_run++;
    end
    if (rst === 1'b0 && dc !== prev_dc && prev_cs !== 1'b1) dc_viol++;
    prev_dc = dc;
    prev_cs = cs;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic d_c, input logic w, input logic [15:0] d);
    in_valid = 1'b1;
    in_dc    = d_c;
    in_wide  = w;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (!(busy === 1'b0 && cs === 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle_in_time"}, 32'(n < budget), 32'd1);
  endtask

  function automatic logic [31:0] get_bits(input int base, input int n);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < n; i++) begin
      v = {v[30:0], (base + i < bits.size()) ? bits[base + i] : 1'b0};
    end
    return v;
  endfunction

  function automatic int count_dc(input int base, input int n);
    int c = 0;
    for (int i = 0; i < n; i++) begin
      if (base + i < bdc.size() && bdc[base + i] === 1'b1) c++;
    end
    return c;
  endfunction

  initial begin
    int b;
    int nl;
    int ng;
    int sent;
    int cyc;
    int full_cycles;
    int max_lvl;
    int order_err;
    int n;
    bit full_ok;
    logic rdy;
    logic [3:0] lvl;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_dc    = 1'b0;
    in_wide  = 1'b0;
    in_data  = 16'h0000;
    repeat (3) @(negedge clk);

    chk("rst_cs", cs, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_sdin", sdin, 0);
    chk("rst_dc", dc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_level", fifo_level, 0);
`ifdef OLED_SPI_TX_WORD_COUNT_EN
    chk("rst_word_count", word_count, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Single command 0xAF: latency P+2, 64-cycle window, bits 1010_1111
    b = bits.size();
    nl = lows.size();
    push(1'b0, 1'b0, 16'h00AF);
    chk("t1_cs_after_push", cs, 1);
    chk("t1_level_after_push", fifo_level, 1);
    chk("t1_busy_after_push", busy, 1);
    @(negedge clk);
    chk("t1_cs_after_pop", cs, 1);
    chk("t1_level_after_pop", fifo_level, 0);
    @(negedge clk);
    chk("t1_cs_low_at_p2", cs, 0);
    chk("t1_first_bit", sdin, 1);
    wait_idle("t1", 200);
    chk("t1_windows", lows.size() - nl, 1);
    chk("t1_low_len", lows[lows.size() - 1], 64);
    chk("t1_nbits", bits.size() - b, 8);
    chk("t1_bits", get_bits(b, 8), 32'h0000_00AF);
    chk("t1_dc_ones", count_dc(b, 8), 0);
    chk("t1_sclk_idle", sclk, 0);

    // Wide burst of three dc=1 words: one unbroken window
    b = bits.size();
    nl = lows.size();
    push(1'b1, 1'b1, 16'hF800);
    push(1'b1, 1'b1, 16'h07E0);
    push(1'b1, 1'b1, 16'h001F);
    wait_idle("t2", 600);
    chk("t2_windows", lows.size() - nl, 1);
    chk("t2_low_len", lows[lows.size() - 1], 384);
    chk("t2_nbits", bits.size() - b, 48);
    chk("t2_word0", get_bits(b, 16), 32'h0000_F800);
    chk("t2_word1", get_bits(b + 16, 16), 32'h0000_07E0);
    chk("t2_word2", get_bits(b + 32, 16), 32'h0000_001F);
    chk("t2_dc_ones", count_dc(b, 48), 48);

    // Command then data: cs high for exactly CS_IDLE cycles between them
    b = bits.size();
    nl = lows.size();
    ng = gaps.size();
    push(1'b0, 1'b0, 16'h0015);
    push(1'b1, 1'b0, 16'h0000);
    wait_idle("t3", 400);
    chk("t3_windows", lows.size() - nl, 2);
    chk("t3_new_gaps", gaps.size() - ng, 2);
    chk("t3_gap_len", gaps[gaps.size() - 1], 2);
    chk("t3_nbits", bits.size() - b, 16);
    chk("t3_cmd_byte", get_bits(b, 8), 32'h0000_0015);
    chk("t3_data_byte", get_bits(b + 8, 8), 32'h0000_0000);
    chk("t3_cmd_dc_ones", count_dc(b, 8), 0);
    chk("t3_data_dc_ones", count_dc(b + 8, 8), 8);
    chk("t3_dc_change_while_cs_low", dc_viol, 0);

    // Backpressure: 20 bytes with in_valid held
    b = bits.size();
    sent = 0;
    cyc = 0;
    full_cycles = 0;
    max_lvl = 0;
    full_ok = 1'b1;
    while (sent < 20 && cyc < 3000) begin
      in_valid = 1'b1;
      in_dc    = 1'b1;
      in_wide  = 1'b0;
      in_data  = 16'(16'h0030 + sent);
      rdy = in_ready;
      lvl = fifo_level;
      if (int'(lvl) > max_lvl) max_lvl = int'(lvl);
      if (lvl == 4'd8) full_cycles++;
      if ((lvl == 4'd8) != (rdy == 1'b0)) full_ok = 1'b0;
      @(negedge clk);
      cyc++;
      if (rdy) sent++;
    end
    in_valid = 1'b0;
    chk("t4_accepted", sent, 20);
    chk("t4_max_level", max_lvl, 8);
    chk("t4_stalled_when_full", 32'(full_cycles > 0), 1);
    chk("t4_ready_iff_not_full", full_ok, 1);
    wait_idle("t4", 2000);
    chk("t4_nbits", bits.size() - b, 160);
    order_err = 0;
    for (int k = 0; k < 20; k++) begin
      if (get_bits(b + 8 * k, 8) != 32'(32'h30 + k)) order_err++;
    end
    chk("t4_order", order_err, 0);
`ifdef OLED_SPI_TX_WORD_COUNT_EN
    chk("t4_word_count", word_count, 26);
`endif

    // Reset during bit 3 of 0xC3 with a second entry still queued
    b = bits.size();
    push(1'b0, 1'b0, 16'h00C3);
    push(1'b0, 1'b0, 16'h005A);
    n = 0;
    while (bits.size() < b + 5 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reached_bit3", bits.size() - b, 5);
    chk("t5_first_bits", get_bits(b, 5), 32'h0000_0018);
    chk("t5_sclk_high", sclk, 1);
    chk("t5_level_before", fifo_level, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_cs", cs, 1);
    chk("t5_sclk", sclk, 0);
    chk("t5_level", fifo_level, 0);
    chk("t5_busy", busy, 0);
    chk("t5_in_ready", in_ready, 1);
    rst = 1'b0;
    @(negedge clk);
    b = bits.size();
    push(1'b1, 1'b0, 16'h0096);
    wait_idle("t5", 200);
    chk("t5_nbits", bits.size() - b, 8);
    chk("t5_byte", get_bits(b, 8), 32'h0000_0096);
`ifdef OLED_SPI_TX_WORD_COUNT_EN
    chk("t5_word_count_after_abort", word_count, 1);
    for (int k = 0; k < 4; k++) push(1'b1, 1'b0, 16'(16'h0040 + k));
    wait_idle("t6", 600);
    chk("t6_word_count_five", word_count, 5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
